// File: rtl/rcv_cu_pkg.sv
// Shared types and defaults for the receive control unit.
// FSM state encoding plus default timeout/counter sizing.
package rcv_cu_pkg;

  typedef enum logic [1:0] {
    WAIT_LSB = 2'b00,
    WAIT_MSB = 2'b01,
    HOLD     = 2'b10,
    ILLEGAL  = 2'b11
  } rcv_state_e;

  localparam int TIMEOUT_CYC_DEF = 1000000;
  localparam int CNT_W_DEF       = 20;

endpackage

// File: rtl/rcv_timeout_cnt.sv
// Saturating inter-byte timeout counter with clear/enable.
// Ports: clk_i, rst_i, clr_i, en_i -> tc_o (count == TIMEOUT_CYC-1).
module rcv_timeout_cnt #(
  parameter int CNT_W       = 20,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] MAX    = '1;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && cnt_q != MAX) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  // Zero timeout disables the terminal count entirely.
  assign tc_o = (TIMEOUT_CYC != 0) && (cnt_q == TC_VAL);

endmodule

// File: rtl/rcv_cu.sv
// Receive control unit: pairs LSB/MSB bytes into a 16-bit FIR sample.
// Ports: clk, rst, RxD_* in, FIR_busy in; FIR_data/FIR_start, error pulses out.
module rcv_cu
  import rcv_cu_pkg::*;
#(
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RxD_data_ready,
  input  logic [7:0]  RxD_data,
  input  logic        FIR_busy,
  output logic [15:0] FIR_data,
  output logic        FIR_start,
  output logic        overrun_err,
  output logic        timeout_err
);

  rcv_state_e  state_q, state_d;
  logic [7:0]  lsb_q, lsb_d;
  logic [15:0] data_q, data_d;
  logic        start_q, start_d;
  logic        ovr_q, ovr_d;
  logic        to_q, to_d;
  logic        cnt_clr, cnt_en, cnt_tc;

  rcv_timeout_cnt #(
    .CNT_W       (CNT_W),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_cnt (
    .clk_i (clk),
    .rst_i (rst),
    .clr_i (cnt_clr),
    .en_i  (cnt_en),
    .tc_o  (cnt_tc)
  );

  always_comb begin
    state_d = state_q;
    lsb_d   = lsb_q;
    data_d  = data_q;
    start_d = 1'b0;
    ovr_d   = 1'b0;
    to_d    = 1'b0;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    unique case (state_q)
      WAIT_LSB: begin
        if (RxD_data_ready) begin
          lsb_d   = RxD_data;
          cnt_clr = 1'b1;
          state_d = WAIT_MSB;
        end
      end
      WAIT_MSB: begin
        // A byte on the timeout cycle wins over the timeout.
        if (RxD_data_ready) begin
          data_d = {RxD_data, lsb_q};
          if (!FIR_busy) begin
            start_d = 1'b1;
            state_d = WAIT_LSB;
          end else begin
            state_d = HOLD;
          end
        end else begin
          cnt_en = 1'b1;
          if (cnt_tc) begin
            to_d    = 1'b1;
            state_d = WAIT_LSB;
          end
        end
      end
      HOLD: begin
        unique case (1'b1)
          !FIR_busy && RxD_data_ready: begin
            start_d = 1'b1;
            lsb_d   = RxD_data;
            cnt_clr = 1'b1;
            state_d = WAIT_MSB;
          end
          !FIR_busy && !RxD_data_ready: begin
            start_d = 1'b1;
            state_d = WAIT_LSB;
          end
          FIR_busy && RxD_data_ready: begin
            ovr_d = 1'b1;
          end
          default: ;
        endcase
      end
      default: state_d = WAIT_LSB;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= WAIT_LSB;
      lsb_q   <= '0;
      data_q  <= '0;
      start_q <= 1'b0;
      ovr_q   <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      lsb_q   <= lsb_d;
      data_q  <= data_d;
      start_q <= start_d;
      ovr_q   <= ovr_d;
      to_q    <= to_d;
    end
  end

  assign FIR_data    = data_q;
  assign FIR_start   = start_q;
  assign overrun_err = ovr_q;
  assign timeout_err = to_q;

endmodule
